// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, loader state encoding and instruction-memory base.
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam int BYTE_W = 8;
   localparam logic [INSTR_W-1:0] IMEM_BASE = '0;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      ERR   = 3'd4,
      CHECK = 3'd5
`else
      ERR   = 3'd4
`endif
   } loader_state_t;
endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream handshake plus instruction-memory write port.
interface inst_mem_loader_if;
   import mips_pkg::*;
   logic byte_valid;
   logic byte_ready;
   logic [BYTE_W-1:0] byte_data;
   logic mem_we;
   logic [INSTR_W-1:0] mem_addr;
   logic [INSTR_W-1:0] mem_wdata;
   modport master(input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
   modport slave(output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// byte_assembler: packs four handshaken bytes MSB-first into a word; word_valid flags the 4th byte.
module byte_assembler
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               hs,
   input  logic [BYTE_W-1:0]  byte_data,
   output logic [INSTR_W-1:0] word,
   output logic               word_valid
);
   logic [1:0] idx;
   logic [INSTR_W-BYTE_W-1:0] shreg;
   assign word = {shreg, byte_data};
   assign word_valid = hs && idx == 2'd3;
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         idx <= '0;
         shreg <= '0;
      end else if (hs) begin
         idx <= idx + 2'd1;
         shreg <= word[INSTR_W-BYTE_W-1:0];
      end
   end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot loader streaming big-endian words into instruction memory, holding the core in reset.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum word verified in CHECK.
module inst_mem_loader
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   word_count,
   inst_mem_loader_if.master  bus,
   output logic               core_reset,
   output logic               busy,
   output logic               done,
   output logic               err
);
   loader_state_t state, nxt;
   logic [CNT_W-1:0] remaining;
   logic [INSTR_W-1:0] word;
   logic word_valid;
   logic hs;
   logic rx_nxt;
   assign hs = bus.byte_valid && bus.byte_ready;
   byte_assembler u_asm (
      .clk(clk),
      .reset(reset),
      .clr(state == IDLE),
      .hs(hs),
      .byte_data(bus.byte_data),
      .word(word),
      .word_valid(word_valid)
   );
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t LAST_ST = CHECK;
   logic [INSTR_W-1:0] xor_acc;
   assign rx_nxt = nxt == RECV || nxt == CHECK;
`else
   localparam loader_state_t LAST_ST = DONE;
   assign rx_nxt = nxt == RECV;
`endif
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (start) nxt = (word_count == '0 || word_count > CNT_W'(DEPTH_WORDS)) ? ERR : RECV;
         RECV:  if (word_valid) nxt = WRITE;
         WRITE: nxt = remaining == CNT_W'(1) ? LAST_ST : RECV;
`ifdef LOADER_CHECKSUM_EN
         CHECK: if (word_valid) nxt = word == xor_acc ? DONE : ERR;
`endif
         default: nxt = state;
      endcase
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         remaining <= '0;
         bus.byte_ready <= 1'b0;
         bus.mem_we <= 1'b0;
         bus.mem_addr <= IMEM_BASE;
         bus.mem_wdata <= '0;
         core_reset <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc <= '0;
`endif
      end else begin
         state <= nxt;
         bus.byte_ready <= rx_nxt;
         bus.mem_we <= nxt == WRITE;
         busy <= rx_nxt || nxt == WRITE;
         done <= nxt == DONE;
         err <= nxt == ERR;
         core_reset <= nxt != DONE;
         if (state == IDLE && nxt == RECV) begin
            remaining <= word_count;
            bus.mem_addr <= IMEM_BASE;
`ifdef LOADER_CHECKSUM_EN
            xor_acc <= '0;
`endif
         end
         if (state == RECV && word_valid) bus.mem_wdata <= word;
         if (state == WRITE) begin
            bus.mem_addr <= bus.mem_addr + INSTR_W'(4);
            remaining <= remaining - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            xor_acc <= xor_acc ^ bus.mem_wdata;
`endif
         end
      end
   end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized loads against a queue-based reference of expected memory writes.
module tb_inst_mem_loader;
   localparam int DEPTH = 256;
   typedef logic [7:0] bq_t[$];
   typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
   logic clk = 0;
   logic reset = 1;
   logic start = 0;
   logic [15:0] word_count = 0;
   logic core_reset, busy, done, err;
   inst_mem_loader_if bus();
   inst_mem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .bus(bus.master), .core_reset(core_reset), .busy(busy), .done(done), .err(err)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int last_wr_cyc = 0;
   wr_t exp_q[$];
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   // Monitor: every write must match the next expected (address, word) pair.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_t e;
         wr_cnt++;
         last_wr_cyc = cyc;
         chk("wr_ready_low", {31'b0, bus.byte_ready}, 0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, e.a);
            chk("wr_data", bus.mem_wdata, e.d);
         end
      end
   end
   task automatic check_reset_vals(input string tag);
      chk({tag, "_core_reset"}, {31'b0, core_reset}, 1);
      chk({tag, "_byte_ready"}, {31'b0, bus.byte_ready}, 0);
      chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_done"}, {31'b0, done}, 0);
      chk({tag, "_err"}, {31'b0, err}, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      start = 0;
      bus.byte_valid = 0;
      repeat (2) @(negedge clk);
      reset = 0;
   endtask
   task automatic feed(input bq_t b, input int mode);
      int i = 0;
      int budget = 0;
      while (i < b.size() && budget < 40 * b.size() + 100) begin
         @(negedge clk);
         budget++;
         bus.byte_valid = mode == 0 ? 1'b1 : mode == 1 ? (budget % 3 == 1) : ($urandom % 3 != 0);
         bus.byte_data = bus.byte_valid ? b[i] : 8'($urandom);
         if (mode == 2) begin
            start = ($urandom % 6 == 0);
            word_count = 16'($urandom);
         end
         if (bus.byte_valid && bus.byte_ready) i++;
      end
      if (i < b.size()) chk("feed_timeout", i, b.size());
      @(negedge clk);
      bus.byte_valid = 0;
      start = 0;
   endtask
   task automatic run_load(input int n, input bq_t b, input int mode, input bit ck_bad);
      logic [31:0] x = 0;
      bit ok = 1;
      int done_cyc = -1;
      do_reset();
      for (int i = 0; i < n; i++) begin
         logic [31:0] w = (32'(b[4*i]) << 24) | (32'(b[4*i+1]) << 16) | (32'(b[4*i+2]) << 8) | 32'(b[4*i+3]);
         exp_q.push_back({32'(4 * i), w});
         x ^= w;
      end
`ifdef LOADER_CHECKSUM_EN
      if (ck_bad) x = ~x;
      ok = !ck_bad;
      for (int k = 3; k >= 0; k--) b.push_back(8'(x >> (8 * k)));
`endif
      @(negedge clk);
      start = 1;
      word_count = 16'(n);
      @(negedge clk);
      start = 0;
      word_count = 16'($urandom);
      chk("busy_after_start", {31'b0, busy}, 1);
      chk("core_reset_loading", {31'b0, core_reset}, 1);
      feed(b, mode);
      for (int k = 0; k < 20; k++) begin
         if (done || err) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("end_done", {31'b0, done}, {31'b0, ok});
      chk("end_err", {31'b0, err}, {31'b0, !ok});
      chk("end_core_reset", {31'b0, core_reset}, {31'b0, !ok});
      chk("end_busy", {31'b0, busy}, 0);
      chk("end_pending_writes", exp_q.size(), 0);
`ifndef LOADER_CHECKSUM_EN
      chk("done_latency", done_cyc, last_wr_cyc + 1);
`endif
      exp_q.delete();
   endtask
   task automatic bad_start(input logic [15:0] cnt);
      int w0;
      do_reset();
      w0 = wr_cnt;
      @(negedge clk);
      start = 1;
      word_count = cnt;
      @(negedge clk);
      start = 0;
      chk("bad_err", {31'b0, err}, 1);
      chk("bad_core_reset", {31'b0, core_reset}, 1);
      chk("bad_busy", {31'b0, busy}, 0);
      repeat (6) begin
         @(negedge clk);
         bus.byte_valid = 1;
         bus.byte_data = 8'($urandom);
         start = $urandom % 2 == 0;
      end
      bus.byte_valid = 0;
      start = 0;
      @(negedge clk);
      chk("bad_no_write", wr_cnt - w0, 0);
      chk("bad_err_sticky", {31'b0, err}, 1);
   endtask
   initial begin
      bq_t base = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
      bq_t b;
      int w0;
      bus.byte_valid = 1;
      bus.byte_data = 8'h5a;
      start = 1;
      word_count = 16'd2;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 0;
      start = 0;
      bus.byte_valid = 0;
      repeat (3) @(negedge clk);
      chk("idle_core_reset", {31'b0, core_reset}, 1);
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_byte_ready", {31'b0, bus.byte_ready}, 0);
      run_load(2, base, 0, 0);
      run_load(2, base, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      run_load(2, base, 0, 1);
`endif
      bad_start(16'd0);
      bad_start(16'(DEPTH + 1));
      do_reset();
      exp_q.push_back({32'h0, 32'h20080005});
      w0 = wr_cnt;
      @(negedge clk);
      start = 1;
      word_count = 16'd3;
      @(negedge clk);
      start = 0;
      feed(base[0:3], 0);
      for (int k = 0; k < 10 && wr_cnt == w0; k++) @(negedge clk);
      chk("midload_first_write", wr_cnt - w0, 1);
      reset = 1;
      @(negedge clk);
      check_reset_vals("midload");
      reset = 0;
      exp_q.delete();
      run_load(1, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, 0);
      for (int t = 0; t < 5; t++) begin
         int n = $urandom_range(1, 6);
         b.delete();
         for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
         run_load(n, b, $urandom % 3, 0);
      end
      b.delete();
      for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom));
      run_load(DEPTH, b, 2, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory; the pipeline fetch stage is the only reader of that memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive word-aligned addresses on the instruction-memory write port, starting at 0x00000000.
- Holds the core in reset until the programmed number of words is loaded, then releases it so fetch starts at PC 0.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in words; word_count above this is an error.
- CNT_W, 16, width of word_count and of the internal words-remaining counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE.
- word_count  input  CNT_W  number of words to load; sampled on the start cycle.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  next stream byte, most significant byte of each word first.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  32  byte address, always a multiple of 4.
- mem_wdata  output  32  instruction word being written.
- core_reset  output  1  reset to PC and pipeline registers.
- busy  output  1  a load is in progress.
- done  output  1  load complete, sticky.
- err  output  1  load rejected or failed, sticky.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, core_reset=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. The byte index and words-remaining counter clear to 0.
- States: IDLE, RECV, WRITE, DONE, ERR; CHECK is added only when the optional feature is enabled.
- IDLE, on start:
  - word_count==0 or word_count>DEPTH_WORDS: go to ERR.
  - Otherwise: latch word_count, set mem_addr=0, byte index=0, and go to RECV.
  - busy rises the cycle after start.
- RECV:
  - byte_ready=1.
  - Each handshake (byte_valid & byte_ready) shifts byte_data in: first byte lands in [31:24], fourth in [7:0].
  - On the 4th handshake go to WRITE.
  - byte_valid without a handshake never changes state; stalls of any length are legal.
- WRITE:
  - Entered the cycle after the 4th handshake; byte_ready=0 and mem_we=1 for exactly one cycle, with mem_wdata = assembled word.
  - On exit, mem_addr += 4 and remaining -= 1.
  - If remaining reaches 0, go to DONE; otherwise return to RECV.
- Throughput: minimum 5 cycles per word.
- DONE: core_reset=0, done=1, busy=0, byte_ready=0. Held until reset.
- ERR: err=1, core_reset=1, busy=0, byte_ready=0. Held until reset. No memory write ever occurs from ERR.
- start outside IDLE is ignored. word_count changes after the start cycle have no effect.
- mem_addr never exceeds 4*(DEPTH_WORDS-1) during a write.
- Reset mid-load: all state returns to reset values next cycle. Words already written remain in memory; a new start rewrites from address 0.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK with byte_ready=1 and accept 4 more bytes forming an expected word; this word is not written.
  - Compare it with the XOR of all written words: match goes to DONE, mismatch goes to ERR.
  - CHECK lasts until the 4th handshake plus one cycle.
- Undefined: CHECK state and XOR accumulator are absent; last WRITE goes straight to DONE.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_W=32 and BYTE_W=8.
  - Loader state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3, ERR=4, CHECK=5).
  - Instruction-memory base address constant (0).
- One sub-module is natural: byte_assembler. It takes a byte handshake, holds a 2-bit index and a 32-bit shift register, and outputs word + word_valid pulse. It is reused for the data word and the checksum word.

Test Plan:
- Reset with arbitrary inputs -> every output equals its reset value. Hold reset 3 cycles, then release with start=0 -> IDLE persists and core_reset stays 1.
- start with word_count=2; bytes 20 08 00 05 20 09 00 07, byte_valid continuous -> exactly two writes: 0x00000000/0x20080005, then 0x00000004/0x20090007. done=1 and core_reset=0 the cycle after the second write.
- Same load with byte_valid gapped (1 on, 2 off) -> byte_ready=0 during each WRITE cycle, unaccepted bytes are not consumed, and the memory contents are identical to the continuous case.
- start with word_count=0, then separately word_count=DEPTH_WORDS+1 (reset between) -> err=1 the cycle after start, mem_we never asserted, core_reset stays 1.
- reset asserted after the first write of a 3-word load -> reset values next cycle. Then start with word_count=1 and bytes AA BB CC DD -> write 0x00000000/0xAABBCCDD, then done.
- With LOADER_CHECKSUM_EN, 2-word load above followed by check bytes 00 01 00 02 -> done=1. Repeat with check bytes 00 00 00 00 -> err=1, core_reset remains 1.
